sim_mem_port: RTL and testbench
===============================

Name: sim_mem_port

Overview:
- Clocked, simulation-only memory port that replaces the combinational DPI memory hook with a valid/ready request/response interface.
- Calls pmem_read_dpi / pmem_write_dpi on request acceptance and returns a response after a configurable fixed latency.
- Supports multiple outstanding requests, bounded by DEPTH.
- Generalises data width to multiples of 64 bits and adds write acknowledges, a misalignment flag and access counters.
- Sits between the core's LSU/IFU bus master and the C++ pmem model in the sim top.

Parameters:
- DATA_W, 64: data width per beat. Must be a multiple of 64; the port has NLANE = DATA_W/64 lanes.
- ADDR_W, 64: address width. Zero-extended to 64 bits for the DPI calls.
- LATENCY, 1: clock edges from request acceptance to resp_valid. Range 1..16.
- DEPTH, 4: maximum requests in flight or awaiting pop. Must be ≥ 1.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  request present
- req_ready  out  1  port can accept a request
- req_wen  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  byte address
- req_wdata  in  DATA_W  write data
- req_wmask  in  DATA_W/8  byte write enables
- resp_valid  out  1  response present
- resp_ready  in  1  consumer takes the response
- resp_rdata  out  DATA_W  read data; 0 for write responses
- resp_is_write  out  1  response belongs to a write
- err_misaligned  out  1  sticky misalignment flag
- rd_count  out  32  accepted reads
- wr_count  out  32  accepted writes

Behaviour:
- Clock and reset: one clock, clk. Reset is rst, synchronous and active-high, sampled at posedge clk.
- Reset values: req_ready=1, resp_valid=0, resp_rdata=0, resp_is_write=0, err_misaligned=0, rd_count=0, wr_count=0. The in-flight count, pipeline valids and FIFO pointers are cleared.
- Reset mid-operation: responses in flight are dropped. Writes already committed to pmem stay committed.
- Accept: a request is accepted at a posedge where req_valid && req_ready && !rst.
- req_ready is registered and equals (inflight < DEPTH). It has no combinational path from resp_ready.
- inflight counter: +1 on accept, -1 on pop (resp_valid && resp_ready). Unchanged when both happen at the same edge. Never exceeds DEPTH.
- Address handling: aligned address A = req_addr with the low log2(DATA_W/8) bits forced to 0.
  - If any of those low bits is nonzero, err_misaligned is set and stays set until rst.
  - The access still proceeds using A.
- DPI on accept, same edge, lanes in ascending order:
  - Read: lane i calls pmem_read_dpi(A+8*i, lane_data). The read is sampled at acceptance, not at response.
  - Write: lane i calls pmem_write_dpi(A+8*i, wdata[64i+:64], wmask[8i+:8]). A lane with mask byte 0 makes no call.
  - The response is still generated in both cases.
- Ordering: DPI calls occur in accept order, so read-after-write returns the new data. Responses return in accept order.
- Pipeline: a non-stalling shift register of LATENCY-1 stages feeds a DEPTH-entry response FIFO.
  - An entry accepted at edge k is in the FIFO after edge k+LATENCY-1.
  - resp_valid=1 from the cycle following edge k+LATENCY-1.
  - The inflight bound guarantees FIFO space, so there is no overflow path.
- Response: resp_valid = FIFO non-empty. resp_rdata and resp_is_write reflect the FIFO head.
  - Head fields hold stable while resp_valid && !resp_ready.
  - Pop at the edge where resp_valid && resp_ready.
- Counters: rd_count / wr_count increment on accept of a read / write. They wrap at 2^32 with no saturation.
- Full condition: with inflight==DEPTH, a pop at edge k makes req_ready=1 from the cycle after edge k.
- Width rules: DPI address is {zero-pad, A}. wmask bit j enables byte j of req_wdata.

Test Plan:
- Reset: assert rst 2 cycles while req_valid=1 -> no DPI calls, all outputs at reset values, rd_count=0.
- Write then read, LATENCY=1, DEPTH=4:
  - Write 0x80000000 data 0x1122334455667788 mask 0xFF.
  - Next cycle read 0x80000000.
  - Expect write resp (is_write=1, rdata=0) one cycle after accept, then read resp rdata=0x1122334455667788; wr_count=1, rd_count=1.
- Partial mask: preload 0xFFFF_FFFF_FFFF_FFFF at 0x80000008, write 0 with mask 0x0F, read back -> 0xFFFFFFFF00000000.
- Backpressure, LATENCY=3, DEPTH=2, resp_ready=0:
  - Issue 3 reads to 0x80000000/08/10.
  - Expect req_ready=0 after 2 accepts and the third held.
  - Raise resp_ready -> responses in order; third accepted after the first pop.
- Misaligned: read 0x80000004 (DATA_W=64) -> err_misaligned=1 stays set, data returned from 0x80000000.
- DATA_W=128 write at 0x80000010 mask 0xFF00 -> exactly one DPI write, addr 0x80000018, mask 0xFF.

Source files
------------

// File: rtl/sim_mem_port_if.sv
`default_nettype none
// ============================================================================
//  Module      : sim_mem_port_if
//  Description : Valid/ready request/response bundle between a bus master
//                (LSU/IFU) and the simulation memory port.
//                master : drives requests, consumes responses
//                slave  : accepts requests, produces responses
//  Revision    : 1.0 - initial release
// ============================================================================
interface sim_mem_port_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 64
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_wen;
    logic [ADDR_W-1:0]     req_addr;
    logic [DATA_W-1:0]     req_wdata;
    logic [DATA_W/8-1:0]   req_wmask;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [DATA_W-1:0]     resp_rdata;
    logic                  resp_is_write;

    modport master (
        output req_valid, req_wen, req_addr, req_wdata, req_wmask, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_is_write
    );

    modport slave (
        input  req_valid, req_wen, req_addr, req_wdata, req_wmask, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_is_write
    );
endinterface
`default_nettype wire

// File: rtl/sim_mem_port.sv
`default_nettype none
// ============================================================================
//  Module      : sim_mem_port
//  Description : Clocked simulation memory port. Accepted requests call the
//                pmem read/write hooks on the accept edge (lanes ascending)
//                and return a response LATENCY edges later, in accept order,
//                with up to DEPTH requests in flight or awaiting pop.
//  Ports       : clk, rst        - clock, synchronous active-high reset
//                bus (slave)     - request/response handshake bundle
//                err_misaligned  - sticky: a request had low address bits set
//                rd_count        - accepted reads  (wrapping)
//                wr_count        - accepted writes (wrapping)
//  Revision    : 1.0 - initial release
// ============================================================================
module sim_mem_port #(
    parameter int DATA_W  = 64,
    parameter int ADDR_W  = 64,
    parameter int LATENCY = 1,
    parameter int DEPTH   = 4
) (
    input  logic                clk,
    input  logic                rst,
    sim_mem_port_if.slave       bus,
    output logic                err_misaligned,
    output logic [31:0]         rd_count,
    output logic [31:0]         wr_count
);
    localparam int C_NLANE  = DATA_W / 64;
    localparam int C_MASK_W = DATA_W / 8;
    localparam int C_OFF_W  = $clog2(C_MASK_W);
    localparam int C_PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int C_CNT_W  = $clog2(DEPTH + 1);
    localparam int C_ENT_W  = DATA_W + 1;   // {is_write, rdata}

    // ------------------------------------------------------------------
    // pmem hooks: a small in-module word store with the pmem call
    // interface.
    // ------------------------------------------------------------------
    logic [63:0] pmem_q [longint unsigned];
    int unsigned pmem_rd_calls;
    int unsigned pmem_wr_calls;

    function automatic void pmem_read_dpi(input longint unsigned addr,
                                          output longint unsigned data);
        pmem_rd_calls = pmem_rd_calls + 1;
        data = pmem_q.exists(addr >> 3) ? pmem_q[addr >> 3] : 64'd0;
    endfunction

    function automatic void pmem_write_dpi(input longint unsigned addr,
                                           input longint unsigned data,
                                           input byte unsigned mask);
        logic [63:0] word;
        pmem_wr_calls = pmem_wr_calls + 1;
        word = pmem_q.exists(addr >> 3) ? pmem_q[addr >> 3] : 64'd0;
        for (int b = 0; b < 8; b++) begin
            if (mask[b]) word[8*b +: 8] = data[8*b +: 8];
        end
        pmem_q[addr >> 3] = word;
    endfunction

    // Performs every lane call for one accepted request; returns read data
    // (zero for writes). Must be invoked exactly once per accept.
    function automatic logic [DATA_W-1:0] pmem_access(
        input logic                wen,
        input logic [63:0]         base,
        input logic [DATA_W-1:0]   wdata,
        input logic [C_MASK_W-1:0] wmask
    );
        logic [DATA_W-1:0] rd;
        longint unsigned   lane;
        rd = '0;
        for (int i = 0; i < C_NLANE; i++) begin
            if (wen) begin
                if (wmask[8*i +: 8] != 8'h00)
                    pmem_write_dpi(base + 64'(8 * i), wdata[64*i +: 64], wmask[8*i +: 8]);
            end else begin
                pmem_read_dpi(base + 64'(8 * i), lane);
                rd[64*i +: 64] = lane;
            end
        end
        return rd;
    endfunction

    function automatic logic [C_PTR_W-1:0] ptr_inc(input logic [C_PTR_W-1:0] p);
        return (p == C_PTR_W'(DEPTH - 1)) ? '0 : p + C_PTR_W'(1);
    endfunction

    // ------------------------------------------------------------------
    // Handshake and bookkeeping
    // ------------------------------------------------------------------
    logic                 req_ready_q, req_ready_d;
    logic [C_CNT_W-1:0]   inflight_q, inflight_d;
    logic [C_CNT_W-1:0]   fifo_cnt_q, fifo_cnt_d;
    logic [C_PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [C_ENT_W-1:0]   fifo_q [DEPTH];
    logic                 err_q;
    logic [31:0]          rd_cnt_q, wr_cnt_q;

    logic                 w_accept, w_pop, w_push, w_resp_valid, w_misaligned;
    logic [ADDR_W-1:0]    w_aligned;
    logic [C_ENT_W-1:0]   w_head;

    assign w_accept     = bus.req_valid && req_ready_q && !rst;
    assign w_resp_valid = (fifo_cnt_q != '0);
    assign w_pop        = w_resp_valid && bus.resp_ready;
    assign w_aligned    = bus.req_addr & ~ADDR_W'(C_MASK_W - 1);
    assign w_misaligned = |bus.req_addr[C_OFF_W-1:0];
    assign w_head       = fifo_q[rd_ptr_q];

    // The inflight bound keeps the FIFO from ever overflowing, so push
    // never needs to consult FIFO occupancy.
    assign inflight_d  = inflight_q + C_CNT_W'(w_accept) - C_CNT_W'(w_pop);
    assign fifo_cnt_d  = fifo_cnt_q + C_CNT_W'(w_push) - C_CNT_W'(w_pop);
    assign req_ready_d = (inflight_d < C_CNT_W'(DEPTH));

    always_ff @(posedge clk) begin
        if (rst) begin
            req_ready_q <= 1'b1;
            inflight_q  <= '0;
            fifo_cnt_q  <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            err_q       <= 1'b0;
            rd_cnt_q    <= '0;
            wr_cnt_q    <= '0;
        end else begin
            req_ready_q <= req_ready_d;
            inflight_q  <= inflight_d;
            fifo_cnt_q  <= fifo_cnt_d;
            if (w_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (w_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            if (w_accept && w_misaligned) err_q <= 1'b1;
            if (w_accept && !bus.req_wen) rd_cnt_q <= rd_cnt_q + 32'd1;
            if (w_accept &&  bus.req_wen) wr_cnt_q <= wr_cnt_q + 32'd1;
        end
    end

    // ------------------------------------------------------------------
    // Latency pipeline feeding the response FIFO
    // ------------------------------------------------------------------
    generate
        if (LATENCY == 1) begin : g_lat1
            assign w_push = w_accept;

            always_ff @(posedge clk) begin
                if (w_accept)
                    fifo_q[wr_ptr_q] <= {bus.req_wen,
                                         pmem_access(bus.req_wen, 64'(w_aligned),
                                                     bus.req_wdata, bus.req_wmask)};
            end
        end else begin : g_latn
            logic [LATENCY-2:0] pipe_v_q;
            logic [C_ENT_W-1:0] pipe_d_q [LATENCY-1];

            assign w_push = pipe_v_q[LATENCY-2];

            always_ff @(posedge clk) begin
                if (rst) begin
                    pipe_v_q <= '0;
                end else begin
                    pipe_v_q[0] <= w_accept;
                    for (int j = 1; j < LATENCY - 1; j++)
                        pipe_v_q[j] <= pipe_v_q[j-1];
                end
            end

            always_ff @(posedge clk) begin
                if (w_accept)
                    pipe_d_q[0] <= {bus.req_wen,
                                    pmem_access(bus.req_wen, 64'(w_aligned),
                                                bus.req_wdata, bus.req_wmask)};
                for (int j = 1; j < LATENCY - 1; j++)
                    pipe_d_q[j] <= pipe_d_q[j-1];
                if (w_push)
                    fifo_q[wr_ptr_q] <= pipe_d_q[LATENCY-2];
            end
        end
    endgenerate

    // Head fields are forced to zero when empty so the reset view is clean.
    assign bus.req_ready     = req_ready_q;
    assign bus.resp_valid    = w_resp_valid;
    assign bus.resp_rdata    = w_resp_valid ? w_head[DATA_W-1:0] : '0;
    assign bus.resp_is_write = w_resp_valid & w_head[DATA_W];
    assign err_misaligned    = err_q;
    assign rd_count          = rd_cnt_q;
    assign wr_count          = wr_cnt_q;
endmodule
`default_nettype wire

// File: tb/tb_sim_mem_port.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sim_mem_port
//  Description : Directed self-checking bench for sim_mem_port. Three
//                instances: A (64b, LATENCY 1, DEPTH 4), B (64b, LATENCY 3,
//                DEPTH 2), C (128b, LATENCY 1, DEPTH 4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sim_mem_port;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    sim_mem_port_if #(.DATA_W(64),  .ADDR_W(64)) bus_a ();
    sim_mem_port_if #(.DATA_W(64),  .ADDR_W(64)) bus_b ();
    sim_mem_port_if #(.DATA_W(128), .ADDR_W(64)) bus_c ();

    logic        err_a, err_b, err_c;
    logic [31:0] rdc_a, wrc_a, rdc_b, wrc_b, rdc_c, wrc_c;

    sim_mem_port #(.DATA_W(64), .ADDR_W(64), .LATENCY(1), .DEPTH(4)) u_a (
        .clk(clk), .rst(rst), .bus(bus_a.slave),
        .err_misaligned(err_a), .rd_count(rdc_a), .wr_count(wrc_a));

    sim_mem_port #(.DATA_W(64), .ADDR_W(64), .LATENCY(3), .DEPTH(2)) u_b (
        .clk(clk), .rst(rst), .bus(bus_b.slave),
        .err_misaligned(err_b), .rd_count(rdc_b), .wr_count(wrc_b));

    sim_mem_port #(.DATA_W(128), .ADDR_W(64), .LATENCY(1), .DEPTH(4)) u_c (
        .clk(clk), .rst(rst), .bus(bus_c.slave),
        .err_misaligned(err_c), .rd_count(rdc_c), .wr_count(wrc_c));

    int unsigned snap_rd, snap_wr;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Holds a request on B until it is accepted (bounded).
    task automatic b_issue(input logic wen, input logic [63:0] addr, input logic [63:0] data);
        logic done;
        done = 1'b0;
        bus_b.req_valid = 1'b1;
        bus_b.req_wen   = wen;
        bus_b.req_addr  = addr;
        bus_b.req_wdata = data;
        bus_b.req_wmask = 8'hFF;
        for (int n = 0; n < 20 && !done; n++) begin
            if (bus_b.req_ready === 1'b1) done = 1'b1;
            tick();
        end
        bus_b.req_valid = 1'b0;
        chk("b_issue_accept", done, 1'b1);
    endtask

    initial begin
        rst = 1'b1;
        bus_a.req_valid = 1'b1; bus_a.req_wen = 1'b0; bus_a.req_addr = 64'h8000_0000;
        bus_a.req_wdata = '0;   bus_a.req_wmask = '0; bus_a.resp_ready = 1'b0;
        bus_b.req_valid = 1'b0; bus_b.req_wen = 1'b0; bus_b.req_addr = '0;
        bus_b.req_wdata = '0;   bus_b.req_wmask = '0; bus_b.resp_ready = 1'b0;
        bus_c.req_valid = 1'b0; bus_c.req_wen = 1'b0; bus_c.req_addr = '0;
        bus_c.req_wdata = '0;   bus_c.req_wmask = '0; bus_c.resp_ready = 1'b0;
        snap_rd = u_a.pmem_rd_calls;
        snap_wr = u_a.pmem_wr_calls;

        // ---------------- reset with req_valid held high ----------------
        tick(); tick();
        chk("rst_dpi_calls",   (u_a.pmem_rd_calls - snap_rd) + (u_a.pmem_wr_calls - snap_wr), 0);
        chk("rst_req_ready",   bus_a.req_ready, 1'b1);
        chk("rst_resp_valid",  bus_a.resp_valid, 1'b0);
        chk("rst_resp_rdata",  bus_a.resp_rdata, 64'd0);
        chk("rst_is_write",    bus_a.resp_is_write, 1'b0);
        chk("rst_err",         err_a, 1'b0);
        chk("rst_rd_count",    rdc_a, 32'd0);
        chk("rst_wr_count",    wrc_a, 32'd0);
        rst = 1'b0;

        // ---------------- A: write then read ----------------
        bus_a.req_valid = 1'b1; bus_a.req_wen = 1'b1; bus_a.req_addr = 64'h8000_0000;
        bus_a.req_wdata = 64'h1122_3344_5566_7788; bus_a.req_wmask = 8'hFF;
        tick();
        chk("wr_resp_valid",   bus_a.resp_valid, 1'b1);
        chk("wr_resp_is_wr",   bus_a.resp_is_write, 1'b1);
        chk("wr_resp_rdata",   bus_a.resp_rdata, 64'd0);
        chk("wr_count_1",      wrc_a, 32'd1);
        bus_a.req_wen = 1'b0;
        tick();
        chk("rd_count_1",      rdc_a, 32'd1);
        chk("head_hold_is_wr", bus_a.resp_is_write, 1'b1);
        bus_a.req_valid = 1'b0; bus_a.resp_ready = 1'b1;
        tick();
        chk("raw_is_wr",       bus_a.resp_is_write, 1'b0);
        chk("raw_rdata",       bus_a.resp_rdata, 64'h1122_3344_5566_7788);
        tick();
        chk("drain_valid",     bus_a.resp_valid, 1'b0);

        // ---------------- A: partial mask ----------------
        bus_a.req_valid = 1'b1; bus_a.req_wen = 1'b1; bus_a.req_addr = 64'h8000_0008;
        bus_a.req_wdata = 64'hFFFF_FFFF_FFFF_FFFF; bus_a.req_wmask = 8'hFF;
        tick();
        bus_a.req_wdata = 64'd0; bus_a.req_wmask = 8'h0F;
        tick();
        bus_a.req_wen = 1'b0;
        tick();
        chk("pmask_is_wr",     bus_a.resp_is_write, 1'b0);
        chk("pmask_rdata",     bus_a.resp_rdata, 64'hFFFF_FFFF_0000_0000);
        bus_a.req_valid = 1'b0;
        tick();

        // ---------------- A: misaligned read ----------------
        bus_a.resp_ready = 1'b0;
        bus_a.req_valid = 1'b1; bus_a.req_wen = 1'b0; bus_a.req_addr = 64'h8000_0004;
        tick();
        chk("mis_err",         err_a, 1'b1);
        chk("mis_rdata",       bus_a.resp_rdata, 64'h1122_3344_5566_7788);
        bus_a.req_valid = 1'b0; bus_a.resp_ready = 1'b1;
        tick(); tick();
        chk("mis_err_sticky",  err_a, 1'b1);
        chk("a_rd_count_3",    rdc_a, 32'd3);
        chk("a_wr_count_3",    wrc_a, 32'd3);

        // ---------------- B: preload, then backpressure ----------------
        bus_b.resp_ready = 1'b1;
        b_issue(1'b1, 64'h8000_0000, 64'hA0);
        b_issue(1'b1, 64'h8000_0008, 64'hA1);
        b_issue(1'b1, 64'h8000_0010, 64'hA2);
        repeat (6) tick();
        chk("b_preload_drain", bus_b.resp_valid, 1'b0);
        bus_b.resp_ready = 1'b0;
        bus_b.req_valid = 1'b1; bus_b.req_wen = 1'b0; bus_b.req_addr = 64'h8000_0000;
        tick();
        bus_b.req_addr = 64'h8000_0008;
        tick();
        chk("bp_ready_low",    bus_b.req_ready, 1'b0);
        chk("bp_rd_count_2",   rdc_b, 32'd2);
        bus_b.req_addr = 64'h8000_0010;
        tick();
        chk("bp_first_resp",   bus_b.resp_rdata, 64'hA0);
        tick();
        chk("bp_hold_rdata",   bus_b.resp_rdata, 64'hA0);
        chk("bp_third_held",   rdc_b, 32'd2);
        bus_b.resp_ready = 1'b1;
        tick();
        chk("bp_second_resp",  bus_b.resp_rdata, 64'hA1);
        chk("bp_ready_back",   bus_b.req_ready, 1'b1);
        chk("bp_not_yet_acc",  rdc_b, 32'd2);
        tick();
        chk("bp_third_acc",    rdc_b, 32'd3);
        chk("bp_gap_valid",    bus_b.resp_valid, 1'b0);
        bus_b.req_valid = 1'b0;
        tick(); tick();
        chk("bp_third_resp",   bus_b.resp_rdata, 64'hA2);
        tick();
        bus_b.resp_ready = 1'b0;

        // ---------------- C: 128-bit upper-lane write ----------------
        bus_c.resp_ready = 1'b1;
        snap_rd = u_c.pmem_rd_calls;
        snap_wr = u_c.pmem_wr_calls;
        bus_c.req_valid = 1'b1; bus_c.req_wen = 1'b1; bus_c.req_addr = 64'h8000_0010;
        bus_c.req_wdata = {64'hCAFE_BABE_DEAD_BEEF, 64'h1111_1111_1111_1111};
        bus_c.req_wmask = 16'hFF00;
        tick();
        chk("w128_wr_calls",   u_c.pmem_wr_calls - snap_wr, 1);
        chk("w128_is_wr",      bus_c.resp_is_write, 1'b1);
        bus_c.req_wen = 1'b0;
        tick();
        chk("w128_rd_calls",   u_c.pmem_rd_calls - snap_rd, 2);
        chk("w128_rdata",      bus_c.resp_rdata, {64'hCAFE_BABE_DEAD_BEEF, 64'd0});
        bus_c.req_valid = 1'b0;
        tick();

        // ---------------- A: reset drops a pending response ----------------
        bus_a.resp_ready = 1'b0;
        bus_a.req_valid = 1'b1; bus_a.req_wen = 1'b0; bus_a.req_addr = 64'h8000_0000;
        tick();
        chk("mid_pending",     bus_a.resp_valid, 1'b1);
        bus_a.req_valid = 1'b0;
        rst = 1'b1;
        tick();
        chk("mid_rst_valid",   bus_a.resp_valid, 1'b0);
        chk("mid_rst_err",     err_a, 1'b0);
        chk("mid_rst_rdcnt",   rdc_a, 32'd0);
        rst = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
